// File: rtl/pri_icache_ctrl_fsm.sv
// Per-core L1 icache control sequencer.
// Serves bypass / flush / selective-flush requests from the icache control
// unit: stalls fetch, drains in-flight refills, clears tag valid bits through
// the shared tag write port and returns level-sensitive acks. It also runs the
// mandatory tag invalidation walk after reset.
module pri_icache_ctrl_fsm #(
  parameter int NB_WAYS    = 4,
  parameter int NB_SETS    = 64,
  parameter int SET_ID_LSB = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       bypass_req_i,
  output logic                       bypass_ack_o,
  input  logic                       flush_req_i,
  output logic                       flush_ack_o,
  input  logic                       sel_flush_req_i,
  input  logic [31:0]                sel_flush_addr_i,
  output logic                       sel_flush_ack_o,
  input  logic                       fetch_busy_i,
  output logic                       fetch_stall_o,
  output logic                       bypass_o,
  output logic                       tag_we_o,
  output logic [$clog2(NB_SETS)-1:0] tag_set_o,
  output logic [NB_WAYS-1:0]         tag_way_be_o,
  input  logic                       tag_gnt_i
);

  localparam int SET_W = $clog2(NB_SETS);
  localparam logic [SET_W-1:0] LAST_SET = SET_W'(NB_SETS - 1);
  localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);
  localparam logic [SET_W-1:0] SET_ZERO = SET_W'(0);

  typedef enum logic [2:0] {
    S_INIT_WALK = 3'd0,
    S_IDLE      = 3'd1,
    S_DRAIN     = 3'd2,
    S_WALK      = 3'd3,
    S_SEL       = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    OP_BYP_ON  = 2'd0,
    OP_BYP_OFF = 2'd1,
    OP_FLUSH   = 2'd2,
    OP_SEL     = 2'd3
  } op_e;

  state_e           state_r;
  state_e           state_nxt_s;
  op_e              op_r;
  op_e              op_pick_s;
  logic [SET_W-1:0] cnt_r;
  logic [SET_W-1:0] sel_set_r;
  logic             bypass_r;
  logic             bypass_ack_r;
  logic             flush_ack_r;
  logic             sel_ack_r;

  logic             walk_last_s;
  logic             byp_pend_s;
  logic             flush_pend_s;
  logic             sel_pend_s;
  logic             any_pend_s;
  logic             done_req_s;
  logic             unused_addr_s;

  // Only the set-index bits of the flush address matter here.
  assign unused_addr_s = ^sel_flush_addr_i;

  assign walk_last_s  = tag_gnt_i && (cnt_r == LAST_SET);
  assign byp_pend_s   = (bypass_req_i != bypass_r);
  assign flush_pend_s = flush_req_i && !flush_ack_r;
  assign sel_pend_s   = sel_flush_req_i && !sel_ack_r;
  assign any_pend_s   = byp_pend_s || flush_pend_s || sel_pend_s;
  // Request line that keeps DONE (and its ack) alive for the current op.
  assign done_req_s   = (op_r == OP_FLUSH) ? flush_req_i : sel_flush_req_i;

  // Priority pick of the pending operation: bypass change, flush, sel flush.
  always_comb begin
    op_pick_s = OP_SEL;
    if (byp_pend_s) begin
      op_pick_s = bypass_r ? OP_BYP_OFF : OP_BYP_ON;
    end else if (flush_pend_s) begin
      op_pick_s = OP_FLUSH;
    end else begin
      op_pick_s = OP_SEL;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= S_INIT_WALK;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_INIT_WALK: begin
        if (walk_last_s) state_nxt_s = S_IDLE;
        else             state_nxt_s = S_INIT_WALK;
      end
      S_IDLE: begin
        if (any_pend_s) state_nxt_s = S_DRAIN;
        else            state_nxt_s = S_IDLE;
      end
      S_DRAIN: begin
        if (fetch_busy_i) begin
          state_nxt_s = S_DRAIN;
        end else begin
          case (op_r)
            OP_BYP_ON:  state_nxt_s = S_IDLE;
            OP_BYP_OFF: state_nxt_s = S_WALK;
            OP_FLUSH:   state_nxt_s = S_WALK;
            OP_SEL:     state_nxt_s = S_SEL;
            default:    state_nxt_s = S_IDLE;
          endcase
        end
      end
      S_WALK: begin
        if (walk_last_s) state_nxt_s = (op_r == OP_BYP_OFF) ? S_IDLE : S_DONE;
        else             state_nxt_s = S_WALK;
      end
      S_SEL: begin
        if (tag_gnt_i) state_nxt_s = S_DONE;
        else           state_nxt_s = S_SEL;
      end
      S_DONE: begin
        if (done_req_s) state_nxt_s = S_DONE;
        else            state_nxt_s = S_IDLE;
      end
      default: state_nxt_s = S_INIT_WALK;
    endcase
  end

  // Outputs decoded purely from the state register.
  always_comb begin
    tag_we_o      = 1'b0;
    fetch_stall_o = 1'b0;
    tag_set_o     = cnt_r;
    case (state_r)
      S_INIT_WALK, S_WALK: begin
        tag_we_o      = 1'b1;
        fetch_stall_o = 1'b1;
        tag_set_o     = cnt_r;
      end
      S_SEL: begin
        tag_we_o      = 1'b1;
        fetch_stall_o = 1'b1;
        tag_set_o     = sel_set_r;
      end
      S_DRAIN: begin
        tag_we_o      = 1'b0;
        fetch_stall_o = 1'b1;
        tag_set_o     = cnt_r;
      end
      default: begin
        tag_we_o      = 1'b0;
        fetch_stall_o = 1'b0;
        tag_set_o     = cnt_r;
      end
    endcase
  end

  assign tag_way_be_o    = {NB_WAYS{1'b1}};
  assign bypass_o        = bypass_r;
  assign bypass_ack_o    = bypass_ack_r;
  assign flush_ack_o     = flush_ack_r;
  assign sel_flush_ack_o = sel_ack_r;

  // Walk set counter: advances on each grant, rearmed to set 0 while draining.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= SET_ZERO;
    end else if ((state_r == S_INIT_WALK || state_r == S_WALK) && tag_gnt_i) begin
      cnt_r <= cnt_r + SET_ONE;
    end else if (state_r == S_DRAIN) begin
      cnt_r <= SET_ZERO;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Latch the picked op and the sel-flush set index when leaving IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_r      <= OP_BYP_ON;
      sel_set_r <= SET_ZERO;
    end else if (state_r == S_IDLE && any_pend_s) begin
      op_r      <= op_pick_s;
      sel_set_r <= sel_flush_addr_i[SET_ID_LSB +: SET_W];
    end else begin
      op_r      <= op_r;
      sel_set_r <= sel_set_r;
    end
  end

  // Bypass state and its ack only change once an entry/exit sequence completes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bypass_r     <= 1'b0;
      bypass_ack_r <= 1'b0;
    end else if (state_r == S_DRAIN && !fetch_busy_i && op_r == OP_BYP_ON) begin
      bypass_r     <= 1'b1;
      bypass_ack_r <= 1'b1;
    end else if (state_r == S_WALK && walk_last_s && op_r == OP_BYP_OFF) begin
      bypass_r     <= 1'b0;
      bypass_ack_r <= 1'b0;
    end else begin
      bypass_r     <= bypass_r;
      bypass_ack_r <= bypass_ack_r;
    end
  end

  // Flush / sel-flush acks: raised on entry to DONE, dropped when the req goes low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flush_ack_r <= 1'b0;
      sel_ack_r   <= 1'b0;
    end else if (state_r == S_WALK && walk_last_s && op_r == OP_FLUSH) begin
      flush_ack_r <= 1'b1;
      sel_ack_r   <= sel_ack_r;
    end else if (state_r == S_SEL && tag_gnt_i) begin
      flush_ack_r <= flush_ack_r;
      sel_ack_r   <= 1'b1;
    end else if (state_r == S_DONE && !done_req_s) begin
      flush_ack_r <= 1'b0;
      sel_ack_r   <= 1'b0;
    end else begin
      flush_ack_r <= flush_ack_r;
      sel_ack_r   <= sel_ack_r;
    end
  end

endmodule

// File: tb/tb_pri_icache_ctrl_fsm.sv
// Self-checking bench for pri_icache_ctrl_fsm. The reference is a
// transaction-level timeline: each operation expects a drain phase that lasts
// until the first cycle with fetch_busy low, then an ordered list of set writes
// consumed one per driven grant, then the ack/bypass outcome of that operation.
module tb_pri_icache_ctrl_fsm;

  localparam int NB_WAYS    = 4;
  localparam int NB_SETS    = 64;
  localparam int SET_ID_LSB = 4;
  localparam int SET_W      = 6;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             bypass_req_i;
  logic             bypass_ack_o;
  logic             flush_req_i;
  logic             flush_ack_o;
  logic             sel_flush_req_i;
  logic [31:0]      sel_flush_addr_i;
  logic             sel_flush_ack_o;
  logic             fetch_busy_i;
  logic             fetch_stall_o;
  logic             bypass_o;
  logic             tag_we_o;
  logic [SET_W-1:0] tag_set_o;
  logic [NB_WAYS-1:0] tag_way_be_o;
  logic             tag_gnt_i;

  int n_vec = 0;
  int n_err = 0;
  bit m_bypass = 1'b0;
  logic [SET_W-1:0] exp_q[$];

  pri_icache_ctrl_fsm #(
    .NB_WAYS(NB_WAYS), .NB_SETS(NB_SETS), .SET_ID_LSB(SET_ID_LSB)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .bypass_req_i(bypass_req_i), .bypass_ack_o(bypass_ack_o),
    .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o),
    .sel_flush_req_i(sel_flush_req_i), .sel_flush_addr_i(sel_flush_addr_i),
    .sel_flush_ack_o(sel_flush_ack_o),
    .fetch_busy_i(fetch_busy_i), .fetch_stall_o(fetch_stall_o),
    .bypass_o(bypass_o), .tag_we_o(tag_we_o), .tag_set_o(tag_set_o),
    .tag_way_be_o(tag_way_be_o), .tag_gnt_i(tag_gnt_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (sample/drive point).
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic pick_gnt(input int mode, input int k);
    if (mode == 0) return 1'b1;
    else if (mode == 1) return (k % 2 == 0) ? 1'b1 : 1'b0;
    else return ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic check_bypass(input string tag);
    check_eq({tag, "_byp"}, {31'd0, bypass_o}, {31'd0, m_bypass});
    check_eq({tag, "_byp_ack"}, {31'd0, bypass_ack_o}, {31'd0, m_bypass});
  endtask

  // Quiet state (IDLE or DONE): no writes, no stall, acks as given.
  task automatic check_idle(input string tag, input logic exp_fa, input logic exp_sa);
    check_eq({tag, "_we"}, {31'd0, tag_we_o}, 32'd0);
    check_eq({tag, "_stall"}, {31'd0, fetch_stall_o}, 32'd0);
    check_eq({tag, "_flush_ack"}, {31'd0, flush_ack_o}, {31'd0, exp_fa});
    check_eq({tag, "_sel_ack"}, {31'd0, sel_flush_ack_o}, {31'd0, exp_sa});
    check_bypass(tag);
  endtask

  task automatic fill_walk();
    exp_q.delete();
    for (int i = 0; i < NB_SETS; i++) exp_q.push_back(SET_W'(i));
  endtask

  // Drain: busy_n cycles with busy high, then one cycle with busy low.
  task automatic do_drain(input int busy_n);
    for (int i = 0; i <= busy_n; i++) begin
      check_eq("drain_we", {31'd0, tag_we_o}, 32'd0);
      check_eq("drain_stall", {31'd0, fetch_stall_o}, 32'd1);
      check_bypass("drain");
      fetch_busy_i = (i < busy_n) ? 1'b1 : 1'b0;
      tick();
    end
  endtask

  // Consume exp_q: each cycle a write of the head set is expected; a driven
  // grant retires it. Optionally stop (without granting) when the head equals abort_at.
  task automatic do_writes(input int mode, input int abort_at, output bit aborted);
    int k;
    int budget;
    k = 0;
    budget = 4 * NB_SETS + 100;
    aborted = 1'b0;
    while (exp_q.size() > 0) begin
      if (budget == 0) begin
        check_eq("write_timeout", exp_q.size(), 32'd0);
        exp_q.delete();
        break;
      end
      if (abort_at >= 0 && int'(exp_q[0]) == abort_at) begin
        aborted = 1'b1;
        return;
      end
      check_eq("wr_we", {31'd0, tag_we_o}, 32'd1);
      check_eq("wr_set", {26'd0, tag_set_o}, {26'd0, exp_q[0]});
      check_eq("wr_stall", {31'd0, fetch_stall_o}, 32'd1);
      check_eq("wr_be", {28'd0, tag_way_be_o}, 32'hF);
      check_eq("wr_flush_ack", {31'd0, flush_ack_o}, 32'd0);
      check_eq("wr_sel_ack", {31'd0, sel_flush_ack_o}, 32'd0);
      check_bypass("wr");
      tag_gnt_i = pick_gnt(mode, k);
      fetch_busy_i = 1'($urandom_range(0, 1));
      if (tag_gnt_i) void'(exp_q.pop_front());
      k++;
      budget--;
      tick();
    end
    tag_gnt_i = 1'($urandom_range(0, 1));
    fetch_busy_i = 1'b0;
  endtask

  task automatic run_flush(input int mode, input int busy_n, input int hold);
    bit ab;
    check_idle("flush_pre", 1'b0, 1'b0);
    flush_req_i = 1'b1;
    tick();
    do_drain(busy_n);
    fill_walk();
    do_writes(mode, -1, ab);
    check_idle("flush_ack", 1'b1, 1'b0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check_idle("flush_hold", 1'b1, 1'b0);
    end
    flush_req_i = 1'b0;
    tick();
    check_idle("flush_clr", 1'b0, 1'b0);
  endtask

  task automatic run_sel(input logic [31:0] addr, input int mode, input int busy_n);
    bit ab;
    check_idle("sel_pre", 1'b0, 1'b0);
    sel_flush_addr_i = addr;
    sel_flush_req_i = 1'b1;
    tick();
    sel_flush_addr_i = $urandom;
    do_drain(busy_n);
    exp_q.delete();
    exp_q.push_back(addr[SET_ID_LSB +: SET_W]);
    do_writes(mode, -1, ab);
    check_idle("sel_ack", 1'b0, 1'b1);
    sel_flush_req_i = 1'b0;
    tick();
    check_idle("sel_clr", 1'b0, 1'b0);
  endtask

  task automatic run_bypass(input logic val, input int busy_n, input int mode);
    bit ab;
    check_idle("byp_pre", 1'b0, 1'b0);
    bypass_req_i = val;
    tick();
    do_drain(busy_n);
    if (val) begin
      m_bypass = 1'b1;
    end else begin
      fill_walk();
      do_writes(mode, -1, ab);
      m_bypass = 1'b0;
    end
    check_idle("byp_done", 1'b0, 1'b0);
  endtask

  initial begin
    bit ab;
    logic [31:0] a;
    rst_ni = 1'b0;
    bypass_req_i = 1'b0;
    flush_req_i = 1'b0;
    sel_flush_req_i = 1'b0;
    sel_flush_addr_i = 32'd0;
    fetch_busy_i = 1'b0;
    tag_gnt_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;

    // Reset values.
    check_eq("rst_we", {31'd0, tag_we_o}, 32'd1);
    check_eq("rst_set", {26'd0, tag_set_o}, 32'd0);
    check_eq("rst_stall", {31'd0, fetch_stall_o}, 32'd1);
    check_eq("rst_be", {28'd0, tag_way_be_o}, 32'hF);
    check_idle_acks: begin
      check_eq("rst_flush_ack", {31'd0, flush_ack_o}, 32'd0);
      check_eq("rst_sel_ack", {31'd0, sel_flush_ack_o}, 32'd0);
      check_bypass("rst");
    end

    // Initial walk with a permanent grant.
    rst_ni = 1'b1;
    fill_walk();
    do_writes(0, -1, ab);
    check_idle("init_done", 1'b0, 1'b0);

    // Directed operations from the test plan.
    run_sel(32'h0000_1230, 0, 0);
    run_flush(1, 0, 2);
    run_bypass(1'b1, 5, 0);
    run_sel(32'h0000_0FF0, 2, 1);
    run_bypass(1'b0, 0, 2);

    // Flush and sel flush raised together: flush first, sel after flush drops.
    a = 32'h0000_0A50;
    check_idle("cc_pre", 1'b0, 1'b0);
    sel_flush_addr_i = a;
    flush_req_i = 1'b1;
    sel_flush_req_i = 1'b1;
    tick();
    do_drain(0);
    fill_walk();
    do_writes(2, -1, ab);
    check_idle("cc_flush_ack", 1'b1, 1'b0);
    flush_req_i = 1'b0;
    tick();
    check_idle("cc_gap", 1'b0, 1'b0);
    tick();
    do_drain(0);
    exp_q.delete();
    exp_q.push_back(a[SET_ID_LSB +: SET_W]);
    do_writes(0, -1, ab);
    check_idle("cc_sel_ack", 1'b0, 1'b1);
    sel_flush_req_i = 1'b0;
    tick();
    check_idle("cc_sel_clr", 1'b0, 1'b0);

    // Randomized operation mix.
    for (int it = 0; it < 12; it++) begin
      int r;
      int mode;
      int busy_n;
      r = $urandom_range(0, 2);
      mode = $urandom_range(0, 2);
      busy_n = $urandom_range(0, 3);
      case (r)
        0: run_flush(mode, busy_n, $urandom_range(0, 2));
        1: run_sel($urandom, mode, busy_n);
        default: run_bypass(~m_bypass, busy_n, mode);
      endcase
    end

    // Reset in the middle of a flush walk at set 30.
    check_idle("mid_pre", 1'b0, 1'b0);
    flush_req_i = 1'b1;
    tick();
    do_drain(1);
    fill_walk();
    do_writes(2, 30, ab);
    check_eq("mid_reached_30", {31'd0, ab}, 32'd1);
    rst_ni = 1'b0;
    flush_req_i = 1'b0;
    bypass_req_i = 1'b0;
    m_bypass = 1'b0;
    #1;
    check_eq("mid_rst_we", {31'd0, tag_we_o}, 32'd1);
    check_eq("mid_rst_set", {26'd0, tag_set_o}, 32'd0);
    check_eq("mid_rst_stall", {31'd0, fetch_stall_o}, 32'd1);
    check_eq("mid_rst_flush_ack", {31'd0, flush_ack_o}, 32'd0);
    check_bypass("mid_rst");
    tick();
    tick();
    rst_ni = 1'b1;
    fill_walk();
    do_writes(2, -1, ab);
    check_idle("mid_init_done", 1'b0, 1'b0);
    tick();
    check_idle("mid_final", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
